// File: rtl/defines.sv
// Shared TBUS field ranges and operation encodings.
`ifndef TBUS_DEFINES_SV
`define TBUS_DEFINES_SV

`define TBUS_OPTYPE_RANGE 1:0
`define TBUS_READ         2'd0
`define TBUS_WRITE        2'd1
`define RESULT_RANGE      63:0
`define SRC_RANGE         63:0

`endif

// File: rtl/tbus_sram_responder.sv
// TBUS responder in front of a single-port doubleword SRAM: one request in flight,
// fixed latency of 3 + EXTRA_LAT cycles, reads abortable by flush, writes not.
`include "defines.sv"

module tbus_sram_responder #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned EXTRA_LAT = 0
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     tbus_index_valid,
   output logic                     tbus_index_ready,
   input  logic [`RESULT_RANGE]     tbus_index,
   input  logic [`SRC_RANGE]        tbus_write_data,
   input  logic [63:0]              tbus_write_mask,
   input  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type,
   output logic [`RESULT_RANGE]     tbus_read_data,
   output logic                     tbus_operation_done,
   input  logic                     flush_valid,
   output logic                     sram_en,
   output logic                     sram_we,
   output logic [ADDR_W-1:0]        sram_addr,
   output logic [63:0]              sram_wdata,
   output logic [63:0]              sram_wmask,
   input  logic [63:0]              sram_rdata
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StWait   = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q;
   logic [63:0]       wmask_q;
   logic              is_write_q;
   logic [63:0]       rdata_q;
   logic [3:0]        cnt_q;
   logic              first_q;

   logic fire;
   logic in_access;
   logic in_done;
   logic read_flush;

   // Byte offset within the doubleword and address bits above the SRAM are don't-care.
   logic unused_index;
   assign unused_index = ^{tbus_index[2:0], tbus_index[63:ADDR_W+3]};

   assign tbus_index_ready = (state_q == StIdle) & ~flush_valid;
   assign fire             = tbus_index_valid & tbus_index_ready;
   assign read_flush       = flush_valid & ~is_write_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         is_write_q <= 1'b0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         first_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (fire) begin
                  addr_q     <= tbus_index[ADDR_W+2:3];
                  wdata_q    <= tbus_write_data;
                  wmask_q    <= tbus_write_mask;
                  is_write_q <= (tbus_operation_type == `TBUS_WRITE);
                  state_q    <= StAccess;
               end
            end
            StAccess: begin
               if (read_flush) begin
                  state_q <= StIdle;
               end else begin
                  state_q <= StWait;
                  cnt_q   <= 4'(EXTRA_LAT);
                  first_q <= 1'b1;
               end
            end
            StWait: begin
               // SRAM read data is only valid in the cycle right after the access.
               if (first_q) begin
                  rdata_q <= is_write_q ? 64'd0 : sram_rdata;
                  first_q <= 1'b0;
               end
               if (read_flush) begin
                  state_q <= StIdle;
               end else if (cnt_q == 4'd0) begin
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_access = (state_q == StAccess);
   assign in_done   = (state_q == StDone);

   assign tbus_operation_done = in_done;
   assign tbus_read_data      = in_done ? rdata_q : 64'd0;

   assign sram_en    = in_access;
   assign sram_we    = in_access & is_write_q;
   assign sram_addr  = in_access ? addr_q : '0;
   assign sram_wdata = in_access ? wdata_q : 64'd0;
   assign sram_wmask = in_access ? wmask_q : 64'd0;

endmodule

// File: tb/tb_tbus_sram_responder.sv
// Bench for tbus_sram_responder: two instances (EXTRA_LAT 0 and 2), each with its own SRAM,
// checked against a transaction-level memory model and the latency/flush rules.
module tb_tbus_sram_responder;

   localparam int unsigned AddrW = 16;
   localparam logic [1:0]  OpRead  = 2'd0;
   localparam logic [1:0]  OpWrite = 2'd1;

   logic clock;
   logic rst_n_s   [2];
   logic valid_s   [2];
   logic ready_s   [2];
   logic [63:0] index_s [2];
   logic [63:0] wdata_s [2];
   logic [63:0] wmask_s [2];
   logic [1:0]  op_s    [2];
   logic [63:0] rd_s    [2];
   logic done_s    [2];
   logic flush_s   [2];
   logic sen_s     [2];
   logic swe_s     [2];
   logic [AddrW-1:0] saddr_s [2];
   logic [63:0] swd_s   [2];
   logic [63:0] swm_s   [2];
   logic [63:0] srd_s   [2];

   // SRAM contents, with a preload port so only one process writes the array.
   logic [63:0] sram_mem [2][32];
   logic        pre_en   [2];
   logic [4:0]  pre_addr [2];
   logic [63:0] pre_data [2];

   logic [63:0] ref_mem  [2][32];

   int n_checks;
   int n_fail;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   tbus_sram_responder #(.ADDR_W(AddrW), .EXTRA_LAT(0)) u_dut0 (
      .clock               (clock),
      .reset_n             (rst_n_s[0]),
      .tbus_index_valid    (valid_s[0]),
      .tbus_index_ready    (ready_s[0]),
      .tbus_index          (index_s[0]),
      .tbus_write_data     (wdata_s[0]),
      .tbus_write_mask     (wmask_s[0]),
      .tbus_operation_type (op_s[0]),
      .tbus_read_data      (rd_s[0]),
      .tbus_operation_done (done_s[0]),
      .flush_valid         (flush_s[0]),
      .sram_en             (sen_s[0]),
      .sram_we             (swe_s[0]),
      .sram_addr           (saddr_s[0]),
      .sram_wdata          (swd_s[0]),
      .sram_wmask          (swm_s[0]),
      .sram_rdata          (srd_s[0])
   );

   tbus_sram_responder #(.ADDR_W(AddrW), .EXTRA_LAT(2)) u_dut2 (
      .clock               (clock),
      .reset_n             (rst_n_s[1]),
      .tbus_index_valid    (valid_s[1]),
      .tbus_index_ready    (ready_s[1]),
      .tbus_index          (index_s[1]),
      .tbus_write_data     (wdata_s[1]),
      .tbus_write_mask     (wmask_s[1]),
      .tbus_operation_type (op_s[1]),
      .tbus_read_data      (rd_s[1]),
      .tbus_operation_done (done_s[1]),
      .flush_valid         (flush_s[1]),
      .sram_en             (sen_s[1]),
      .sram_we             (swe_s[1]),
      .sram_addr           (saddr_s[1]),
      .sram_wdata          (swd_s[1]),
      .sram_wmask          (swm_s[1]),
      .sram_rdata          (srd_s[1])
   );

   for (genvar g = 0; g < 2; g++) begin : g_sram
      always @(posedge clock) begin
         if (pre_en[g]) begin
            sram_mem[g][pre_addr[g]] <= pre_data[g];
         end else if (sen_s[g]) begin
            if (swe_s[g]) begin
               sram_mem[g][saddr_s[g][4:0]] <= (sram_mem[g][saddr_s[g][4:0]] & ~swm_s[g])
                                               | (swd_s[g] & swm_s[g]);
            end
            srd_s[g] <= sram_mem[g][saddr_s[g][4:0]];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   task automatic preload(input int d, input int a, input logic [63:0] v);
      @(negedge clock);
      pre_en[d]   = 1'b1;
      pre_addr[d] = 5'(a);
      pre_data[d] = v;
      ref_mem[d][a] = v;
      @(negedge clock);
      pre_en[d] = 1'b0;
   endtask

   task automatic idle_cycles(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         valid_s[d] = 1'b0;
         flush_s[d] = 1'b0;
         #1;
         check("idle_ready", 64'(ready_s[d]), 64'd1);
         check("idle_done", 64'(done_s[d]), 64'd0);
         check("idle_sram_en", 64'(sen_s[d]), 64'd0);
      end
   endtask

   // One request: fire in cycle 0, then walk to the expected done cycle.
   // flush_rel = cycle (relative to fire) carrying flush_valid, 0 for none.
   task automatic run_txn(input int d, input logic [1:0] op, input logic [63:0] idx,
                          input logic [63:0] wd, input logic [63:0] wm,
                          input int flush_rel, input bit hold);
      int          dl;
      int          a;
      bit          is_wr;
      bit          abort;
      bit          idle;
      bit          exp_done;
      logic [63:0] exp_rd;
      dl     = 3 + lat_of(d);
      a      = int'(idx[7:3]);
      is_wr  = (op == OpWrite);
      abort  = !is_wr && flush_rel >= 1 && flush_rel <= dl - 1;
      exp_rd = is_wr ? 64'd0 : ref_mem[d][a];

      @(negedge clock);
      valid_s[d] = 1'b1;
      index_s[d] = idx;
      wdata_s[d] = wd;
      wmask_s[d] = wm;
      op_s[d]    = op;
      flush_s[d] = 1'b0;
      #1;
      check("ready_at_fire", 64'(ready_s[d]), 64'd1);
      if (is_wr) ref_mem[d][a] = (ref_mem[d][a] & ~wm) | (wd & wm);

      for (int r = 1; r <= dl; r++) begin
         @(negedge clock);
         valid_s[d] = hold;
         flush_s[d] = (r == flush_rel);
         #1;
         idle     = abort && (r > flush_rel);
         exp_done = (r == dl) && !abort;
         check("ready_busy", 64'(ready_s[d]), 64'(idle && !flush_s[d]));
         check("done", 64'(done_s[d]), 64'(exp_done));
         check("read_data", rd_s[d], exp_done ? exp_rd : 64'd0);
         check("sram_en", 64'(sen_s[d]), 64'(r == 1));
         if (r == 1) begin
            check("sram_addr", 64'(saddr_s[d]), 64'(idx[AddrW+2:3]));
            check("sram_we", 64'(swe_s[d]), 64'(is_wr));
            check("sram_wdata", swd_s[d], wd);
            check("sram_wmask", swm_s[d], wm);
         end else begin
            check("sram_we_off", 64'(swe_s[d]), 64'd0);
            check("sram_wmask_off", swm_s[d], 64'd0);
         end
      end
   endtask

   task automatic check_reset_outputs(input int d);
      check("rst_done", 64'(done_s[d]), 64'd0);
      check("rst_read_data", rd_s[d], 64'd0);
      check("rst_sram_en", 64'(sen_s[d]), 64'd0);
      check("rst_sram_we", 64'(swe_s[d]), 64'd0);
      check("rst_sram_addr", 64'(saddr_s[d]), 64'd0);
      check("rst_sram_wdata", swd_s[d], 64'd0);
      check("rst_sram_wmask", swm_s[d], 64'd0);
   endtask

   task automatic reset_mid_access(input int d, input logic [63:0] idx);
      @(negedge clock);
      valid_s[d] = 1'b1;
      index_s[d] = idx;
      op_s[d]    = OpRead;
      flush_s[d] = 1'b0;
      #1;
      check("rm_ready_fire", 64'(ready_s[d]), 64'd1);
      @(negedge clock);
      valid_s[d] = 1'b0;
      #1;
      check("rm_in_access", 64'(sen_s[d]), 64'd1);
      rst_n_s[d] = 1'b0;
      #1;
      check_reset_outputs(d);
      @(negedge clock);
      rst_n_s[d] = 1'b1;
      @(negedge clock);
      #1;
      check("rm_ready_after", 64'(ready_s[d]), 64'd1);
      idle_cycles(d, 4);
   endtask

   task automatic random_txns(input int d, input int n);
      logic [1:0]  op;
      logic [63:0] idx;
      logic [63:0] wd;
      logic [63:0] wm;
      int          fr;
      for (int i = 0; i < n; i++) begin
         op  = 2'($urandom_range(0, 3));
         idx = {$urandom, $urandom};
         wd  = {$urandom, $urandom};
         wm  = {$urandom, $urandom};
         fr  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3 + lat_of(d)));
         run_txn(d, op, idx, wd, wm, fr, 1'b0);
         if ($urandom_range(0, 3) == 0) idle_cycles(d, 1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int d = 0; d < 2; d++) begin
         rst_n_s[d]  = 1'b0;
         valid_s[d]  = 1'b0;
         index_s[d]  = '0;
         wdata_s[d]  = '0;
         wmask_s[d]  = '0;
         op_s[d]     = OpRead;
         flush_s[d]  = 1'b0;
         pre_en[d]   = 1'b0;
         pre_addr[d] = '0;
         pre_data[d] = '0;
      end
      repeat (2) @(negedge clock);
      #1;
      for (int d = 0; d < 2; d++) check_reset_outputs(d);

      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 32; a++) preload(d, a, 64'(a) * 64'h0101_0101_0101_0101);
         preload(d, 16, 64'h1122_3344_5566_7788);
      end

      @(negedge clock);
      rst_n_s[0] = 1'b1;
      rst_n_s[1] = 1'b1;
      @(negedge clock);
      #1;
      check("ready_out_of_reset0", 64'(ready_s[0]), 64'd1);
      check("ready_out_of_reset2", 64'(ready_s[1]), 64'd1);

      // Directed, EXTRA_LAT = 0.
      run_txn(0, OpRead, 64'h80, 64'd0, 64'd0, 0, 1'b0);
      run_txn(0, OpWrite, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, 0, 1'b0);
      run_txn(0, OpRead, 64'h85, 64'd0, 64'd0, 0, 1'b0);
      check("merged_word", ref_mem[0][16], 64'h1122_3344_FFFF_7788);
      run_txn(0, OpRead, 64'h80, 64'd0, 64'd0, 2, 1'b0);
      run_txn(0, OpRead, 64'h88, 64'd0, 64'd0, 0, 1'b0);
      run_txn(0, OpWrite, 64'h90, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
      run_txn(0, OpRead, 64'h90, 64'd0, 64'd0, 0, 1'b0);
      run_txn(0, OpRead, 64'h90, 64'd0, 64'd0, 1, 1'b0);
      run_txn(0, OpRead, 64'h80, 64'd0, 64'd0, 3, 1'b0);
      run_txn(0, 2'd2, 64'h98, 64'hFFFF, 64'hFFFF, 0, 1'b0);
      run_txn(0, 2'd3, 64'h98, 64'hFFFF, 64'hFFFF, 0, 1'b0);

      // Flush together with valid in idle must not accept.
      @(negedge clock);
      valid_s[0] = 1'b1;
      index_s[0] = 64'h80;
      op_s[0]    = OpWrite;
      flush_s[0] = 1'b1;
      #1;
      check("flush_idle_ready", 64'(ready_s[0]), 64'd0);
      idle_cycles(0, 2);

      reset_mid_access(0, 64'h80);
      run_txn(0, OpRead, 64'h80, 64'd0, 64'd0, 0, 1'b0);
      random_txns(0, 40);
      idle_cycles(0, 1);

      // EXTRA_LAT = 2: back-to-back with valid held high, then flush at counter expiry.
      for (int i = 0; i < 4; i++) begin
         run_txn(1, OpRead, 64'h80 + 64'(i * 8), 64'd0, 64'd0, 0, 1'b1);
      end
      idle_cycles(1, 1);
      run_txn(1, OpRead, 64'h80, 64'd0, 64'd0, 4, 1'b0);
      run_txn(1, OpWrite, 64'h80, 64'h1234, 64'hFF00, 2, 1'b0);
      run_txn(1, OpRead, 64'h80, 64'd0, 64'd0, 5, 1'b0);
      random_txns(1, 30);
      idle_cycles(1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tbus_sram_responder.md
TBUS_SRAM_RESPONDER -- requirements
Module: tbus_sram_responder

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16: SRAM doubleword address width.
REQ-002 The block SHALL take parameter EXTRA_LAT, default 0: added wait cycles before completion, range 0..15.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset; reset_n is asynchronous and active-low.
REQ-004 The block SHALL have port clock, input, 1, sole clock (rising edge).
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port tbus_index_valid, input, 1, initiator request valid.
REQ-007 The block SHALL have port tbus_index_ready, output, 1, responder can accept a request.
REQ-008 The block SHALL have port tbus_index, input, `RESULT_RANGE (64), byte address.
REQ-009 The block SHALL have port tbus_write_data, input, `SRC_RANGE (64), store data.
REQ-010 The block SHALL have port tbus_write_mask, input, 64, per-bit write enable.
REQ-011 The block SHALL have port tbus_operation_type, input, `TBUS_OPTYPE_RANGE, `TBUS_READ or `TBUS_WRITE.
REQ-012 The block SHALL have port tbus_read_data, output, `RESULT_RANGE (64), full aligned doubleword.
REQ-013 The block SHALL have port tbus_operation_done, output, 1, single-cycle completion pulse.
REQ-014 The block SHALL have port flush_valid, input, 1, arbiter flush that aborts in-flight reads.
REQ-015 The block SHALL have ports sram_en (output, 1), sram_we (output, 1), sram_addr (output, ADDR_W), sram_wdata (output, 64), sram_wmask (output, 64), and sram_rdata (input, 64); sram_rdata is valid the cycle after sram_en.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ACCESS, WAIT, DONE.
REQ-017 tbus_index_ready SHALL equal (state==IDLE) & ~flush_valid.
REQ-018 The block SHALL accept a request (fire) when valid & ready, latching index, write_data, write_mask and optype; the FSM SHALL then go IDLE->ACCESS.
REQ-019 In ACCESS for exactly one cycle, the block SHALL drive sram_en=1, sram_we=(optype==`TBUS_WRITE), sram_addr=index_latch[ADDR_W+2:3], sram_wdata and sram_wmask from their latches, then go to WAIT; it SHALL ignore index bits [2:0].
REQ-020 On the first WAIT cycle the block SHALL capture sram_rdata into rdata_reg for reads; for writes it SHALL load rdata_reg with 0.
REQ-021 A 4-bit counter SHALL load EXTRA_LAT on entry to WAIT; WAIT SHALL exit to DONE when the counter is 0, and otherwise decrement the counter.
REQ-022 In DONE the block SHALL assert tbus_operation_done=1 for one cycle with tbus_read_data=rdata_reg, then go to IDLE.
REQ-023 Latency SHALL be 3+EXTRA_LAT cycles from the fire cycle T to the done cycle; maximum throughput SHALL be one request per 4+EXTRA_LAT cycles.
REQ-024 Outside DONE the block SHALL drive tbus_operation_done=0 and tbus_read_data=0; it SHALL drive sram_en, sram_we, sram_wdata and sram_wmask to 0 outside ACCESS.
REQ-025 On flush_valid during ACCESS, WAIT or DONE of a read, the FSM SHALL go to IDLE at the next edge; no done pulse SHALL follow, and if flush_valid hits the DONE cycle itself, that done pulse SHALL still be emitted.
REQ-026 Writes SHALL be immune to flush: the SRAM write is performed and the done pulse is emitted.
REQ-027 flush_valid together with tbus_index_valid in IDLE SHALL result in no acceptance, because ready is 0.
REQ-028 An optype other than `TBUS_READ or `TBUS_WRITE SHALL be treated as a read.
REQ-029 Simultaneous flush_valid and counter expiry SHALL be resolved in favour of the flush for reads.

Reset
REQ-030 Asserting reset_n low SHALL force the FSM to IDLE, clear all latches, rdata_reg and the counter, and drive all outputs to 0 except tbus_index_ready.
REQ-031 tbus_index_ready SHALL read 1 one cycle into reset deassertion, i.e. in IDLE with no flush.
REQ-032 Reset mid-operation SHALL abandon the request with no done pulse; an SRAM write already issued SHALL not be undone.

Structure
REQ-033 `TBUS_OPTYPE_RANGE, `TBUS_READ, `TBUS_WRITE, `RESULT_RANGE and `SRC_RANGE SHALL come from defines.sv, and the block SHALL define no new shared constants.
REQ-034 FSM state encodings SHALL be localparams; the block SHALL be a single flat module with no sub-module.

Verification
REQ-035 With SRAM[0x10]=0x1122334455667788 and EXTRA_LAT=0, a read of index 0x80 fired at cycle 5 SHALL produce done in cycle 8 with read_data=0x1122334455667788.
REQ-036 A write to 0x80 with data 0xFFFF_FFFF_FFFF_FFFF and mask 0x0000_0000_FFFF_0000, followed by a read of 0x80, SHALL return 0x11223344FFFF7788 and a write done with read_data=0.
REQ-037 A read fired, then flush_valid asserted in WAIT, SHALL produce no done pulse; ready SHALL be 1 on the next cycle and a new read SHALL complete normally.
REQ-038 Back-to-back reads with valid held high and EXTRA_LAT=2 SHALL be accepted every 6 cycles, each completing 5 cycles after its fire.
REQ-039 reset_n pulsed low in ACCESS of a read SHALL give no done and all outputs 0, and ready SHALL be 1 after release.
REQ-040 A write fired, then flush_valid asserted in ACCESS, SHALL still update the SRAM and emit done at T+3.
